// File: rtl/pool_pkg.sv
// Shared definitions for the streaming pooling stage: mode encoding and signed saturation.
package pool_pkg;

  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;

  // Clamp a wide signed value into the signed range of 'width' bits.
  function automatic logic signed [63:0] sat_s(input logic signed [63:0] value, input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    else if (value < lo) return lo;
    else return value;
  endfunction

endpackage

// File: rtl/pool_lane.sv
// One channel lane: running max (and, with POOL_AVG_EN, running sum) plus result formatting.
// result is combinational and already includes the beat currently presented on din.
module pool_lane
  import pool_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 20,
  parameter int AVG_SHIFT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     beat_en,
  input  logic                     first,
  input  logic                     avg_sel,
  input  logic signed [DATA_W-1:0] din,
  output logic        [DATA_W-1:0] result
);

  logic signed [DATA_W-1:0] max_q;
  logic signed [DATA_W-1:0] max_nxt;

  always_comb begin
    max_nxt = max_q;
    if (first || (din > max_q)) max_nxt = din;
  end

  always_ff @(posedge clk) begin
    if (rst) max_q <= '0;
    else if (beat_en) max_q <= max_nxt;
  end

`ifdef POOL_AVG_EN
  logic signed [ACC_W-1:0]  sum_q;
  logic signed [ACC_W-1:0]  sum_nxt;
  logic signed [ACC_W-1:0]  sum_shr;
  logic signed [DATA_W-1:0] avg_val;

  always_comb begin
    sum_nxt = first ? ACC_W'(din) : sum_q + ACC_W'(din);
    sum_shr = sum_nxt >>> AVG_SHIFT;
    avg_val = DATA_W'(sat_s(64'(sum_shr), DATA_W));
  end

  always_ff @(posedge clk) begin
    if (rst) sum_q <= '0;
    else if (beat_en) sum_q <= sum_nxt;
  end

  assign result = avg_sel ? avg_val : max_nxt;
`else
  logic        unused_avg_sel;
  logic [31:0] unused_cfg;
  assign unused_avg_sel = avg_sel;
  assign unused_cfg     = 32'(ACC_W + AVG_SHIFT);
  assign result         = max_nxt;
`endif

endmodule

// File: rtl/pooling_stream.sv
// Streaming CH-lane pooling stage: reduces WIN beats per window to one result per lane.
// Max pooling always; shifted-sum average when built with POOL_AVG_EN.
module pooling_stream
  import pool_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int CH        = 4,
  parameter int WIN       = 9,
  parameter int AVG_SHIFT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH*DATA_W-1:0] in_data,
  input  logic                 in_last,
  input  logic                 mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH*DATA_W-1:0] out_data,
  output logic                 frame_err
);

  localparam int ACC_W = DATA_W + $clog2(WIN);
  localparam int CNT_W = $clog2(WIN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIN - 1);

  logic [CNT_W-1:0]       count;
  logic                   accept;
  logic                   first_beat;
  logic                   last_beat;
  logic                   beat_err;
  logic                   lane_en;
  logic                   avg_sel;
  logic [CH*DATA_W-1:0]   lane_result;

  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign first_beat = (count == '0);
  assign last_beat  = (count == LAST_CNT);
  assign beat_err   = (in_last != last_beat);
  assign lane_en    = accept && !clear;

`ifdef POOL_AVG_EN
  // Mode is captured with the first beat so a mid-window change cannot mix reductions.
  logic mode_q;
  always_ff @(posedge clk) begin
    if (rst) mode_q <= POOL_MAX;
    else if (lane_en && first_beat) mode_q <= mode;
  end
  assign avg_sel = (mode_q == POOL_AVG);
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign avg_sel     = POOL_MAX;
`endif

  for (genvar i = 0; i < CH; i++) begin : g_lane
    pool_lane #(
      .DATA_W   (DATA_W),
      .ACC_W    (ACC_W),
      .AVG_SHIFT(AVG_SHIFT)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .beat_en(lane_en),
      .first  (first_beat),
      .avg_sel(avg_sel),
      .din    (in_data[i*DATA_W +: DATA_W]),
      .result (lane_result[i*DATA_W +: DATA_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      frame_err <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (clear) begin
        count <= '0;
      end else if (accept) begin
        if (beat_err) begin
          frame_err <= 1'b1;
          count     <= '0;
        end else if (last_beat) begin
          // A completion in the same cycle as a drain overrides the clear of out_valid above.
          count     <= '0;
          out_valid <= 1'b1;
          out_data  <= lane_result;
        end else begin
          count <= count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pooling_stream.sv
// Directed/random bench for pooling_stream; expected results come from a per-window arithmetic model.
module tb_pooling_stream;

  localparam int DATA_W    = 16;
  localparam int CH        = 4;
  localparam int WIN       = 9;
  localparam int AVG_SHIFT = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 clear = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [CH*DATA_W-1:0] in_data = '0;
  logic                 in_last = 1'b0;
  logic                 mode = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [CH*DATA_W-1:0] out_data;
  logic                 frame_err;

  int checks = 0;
  int errors = 0;
  int win_vals [WIN][CH];
  logic [63:0] exp_data;
  logic [63:0] held;

  pooling_stream #(
    .DATA_W(DATA_W), .CH(CH), .WIN(WIN), .AVG_SHIFT(AVG_SHIFT)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fill_random();
    for (int b = 0; b < WIN; b++)
      for (int c = 0; c < CH; c++)
        win_vals[b][c] = int'($urandom_range(65535)) - 32768;
  endtask

  // Reference: max of the window, or floor(sum / 2^AVG_SHIFT) clamped to 16-bit signed.
  function automatic logic [63:0] model(input bit md);
    logic [63:0] r;
    bit avg;
`ifdef POOL_AVG_EN
    avg = md;
`else
    avg = 1'b0;
`endif
    r = '0;
    for (int c = 0; c < CH; c++) begin
      int v;
      if (avg) begin
        int s;
        s = 0;
        for (int b = 0; b < WIN; b++) s += win_vals[b][c];
        v = s >>> AVG_SHIFT;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
      end else begin
        v = win_vals[0][c];
        for (int b = 1; b < WIN; b++) if (win_vals[b][c] > v) v = win_vals[b][c];
      end
      r[c*16 +: 16] = 16'(v);
    end
    return r;
  endfunction

  task automatic drive_beat(input int b, input bit last, input bit md);
    in_valid = 1'b1;
    in_last  = last;
    mode     = md;
    for (int c = 0; c < CH; c++) in_data[c*DATA_W +: DATA_W] = 16'(win_vals[b][c]);
  endtask

  task automatic send_window(input int n, input int last_at, input bit md0, input bit md_rest);
    for (int b = 0; b < n; b++) begin
      @(negedge clk);
      drive_beat(b, (b == last_at), (b == 0) ? md0 : md_rest);
    end
  endtask

  task automatic end_window(input string tag, input bit exp_valid, input logic [63:0] exp_d);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check({tag, "_valid"}, 64'(out_valid), 64'(exp_valid));
    if (exp_valid) check({tag, "_data"}, out_data, exp_d);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", out_data, 64'd0);
    check("rst_ferr", 64'(frame_err), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);

    // 1: directed lane0 sequence, random other lanes
    fill_random();
    begin
      int seq [WIN] = '{-5, 3, -1, 7, 0, 2, -8, 6, 1};
      for (int b = 0; b < WIN; b++) win_vals[b][0] = seq[b];
    end
    exp_data = model(1'b0);
    send_window(WIN, WIN - 1, 1'b0, 1'b0);
    end_window("t1", 1'b1, exp_data);
    check("t1_lane0", 64'(out_data[15:0]), 64'h0007);

    // 2: saturated extremes
    fill_random();
    for (int b = 0; b < WIN; b++) begin
      win_vals[b][1] = -32768;
      if (win_vals[b][2] == 32767) win_vals[b][2] = 0;
    end
    win_vals[4][2] = 32767;
    exp_data = model(1'b0);
    send_window(WIN, WIN - 1, 1'b0, 1'b0);
    end_window("t2", 1'b1, exp_data);
    check("t2_lane1_min", 64'(out_data[31:16]), 64'h8000);
    check("t2_lane2_max", 64'(out_data[47:32]), 64'h7fff);

    // 3: backpressure, then full-rate streaming
    @(negedge clk);
    out_ready = 1'b0;
    fill_random();
    exp_data = model(1'b0);
    send_window(WIN, WIN - 1, 1'b0, 1'b0);
    end_window("t3_stall", 1'b1, exp_data);
    check("t3_in_ready_low", 64'(in_ready), 64'd0);
    held = exp_data;
    fill_random();
    for (int k = 0; k < 3; k++) begin
      drive_beat(k, 1'b1, 1'b0);
      @(negedge clk);
      check("t3_hold_valid", 64'(out_valid), 64'd1);
      check("t3_hold_data", out_data, held);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("t3_drained", 64'(out_valid), 64'd0);
    for (int w = 0; w < 3; w++) begin
      for (int b = 0; b < WIN; b++) begin
        if (b == 0) begin
          if (w > 0) begin
            check("t3_stream_valid", 64'(out_valid), 64'd1);
            check("t3_stream_data", out_data, exp_data);
          end
          fill_random();
          exp_data = model(1'b0);
        end else begin
          check("t3_no_bubble_valid", 64'(out_valid), 64'd0);
        end
        drive_beat(b, (b == WIN - 1), 1'b0);
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("t3_last_valid", 64'(out_valid), 64'd1);
    check("t3_last_data", out_data, exp_data);

    // 4: framing errors (early last, then missing last)
    fill_random();
    send_window(4, 3, 1'b0, 1'b0);
    end_window("t4_early", 1'b0, '0);
    check("t4_ferr", 64'(frame_err), 64'd1);
    fill_random();
    exp_data = model(1'b0);
    send_window(WIN, WIN - 1, 1'b0, 1'b0);
    end_window("t4_good", 1'b1, exp_data);
    check("t4_ferr_sticky", 64'(frame_err), 64'd1);
    fill_random();
    send_window(WIN, -1, 1'b0, 1'b0);
    end_window("t4_nolast", 1'b0, '0);
    fill_random();
    exp_data = model(1'b0);
    send_window(WIN, WIN - 1, 1'b0, 1'b0);
    end_window("t4_recover", 1'b1, exp_data);

    // 5: clear mid-window (with a dropped beat), then reset mid-window
    for (int b = 0; b < WIN; b++)
      for (int c = 0; c < CH; c++) win_vals[b][c] = 32767;
    send_window(6, -1, 1'b0, 1'b0);
    @(negedge clk);
    drive_beat(0, 1'b0, 1'b0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    fill_random();
    for (int b = 0; b < WIN; b++)
      for (int c = 0; c < CH; c++) if (win_vals[b][c] == 32767) win_vals[b][c] = 100;
    exp_data = model(1'b0);
    send_window(WIN, WIN - 1, 1'b0, 1'b0);
    end_window("t5_clear", 1'b1, exp_data);
    fill_random();
    send_window(5, -1, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_valid", 64'(out_valid), 64'd0);
    check("t5_rst_data", out_data, 64'd0);
    check("t5_rst_ferr", 64'(frame_err), 64'd0);
    fill_random();
    exp_data = model(1'b0);
    send_window(WIN, WIN - 1, 1'b0, 1'b0);
    end_window("t5_restart", 1'b1, exp_data);

    // 6: mode=1 (average when built in, max otherwise); mode latched on first beat
    fill_random();
    exp_data = model(1'b1);
    send_window(WIN, WIN - 1, 1'b1, 1'b0);
    end_window("t6_rand_mode1", 1'b1, exp_data);
    fill_random();
    exp_data = model(1'b0);
    send_window(WIN, WIN - 1, 1'b0, 1'b1);
    end_window("t6_rand_mode0", 1'b1, exp_data);
    for (int b = 0; b < WIN; b++) begin
      win_vals[b][0] = 10 * (b + 1);
      win_vals[b][1] = -32768;
      win_vals[b][2] = -3;
      win_vals[b][3] = 32767;
    end
    exp_data = model(1'b1);
    send_window(WIN, WIN - 1, 1'b1, 1'b1);
    end_window("t6_directed", 1'b1, exp_data);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
